pipe_sel_stage: RTL

//  Parametrised M-way, N-bit selector followed by a registered pipeline stage.
//  The stage carries a valid/ready handshake and a 2-entry skid buffer.
//  It supersedes the combinational 2:1 N-bit mux at pipeline boundaries
//  (forwarding/operand select into ID/EX, EX/MEM). It adds stall, flush and

---
 rtl/pipe_sel_stage.sv | 64 ++++++
 1 files changed

// File: rtl/pipe_sel_stage.sv
// pipe_sel_stage: M-way N-bit selector into a valid/ready register stage with a 2-entry skid buffer
module pipe_sel_stage #(
  parameter int N  = 32,
  parameter int M  = 4,
  parameter int SW = $clog2(M)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [M*N-1:0] in_data,
  input  logic [SW-1:0]  sel,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           flush,
  output logic [N-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_selerr
);
  logic [N-1:0] sel_data, main_data, skid_data;
  logic         sel_err, main_err, skid_err, main_valid, skid_valid;
  logic         acc, emit;
  always_comb begin
    sel_data = '0;
    sel_err  = 1'b1;
    for (int k = 0; k < M; k++)
      if (sel == SW'(k)) begin
        sel_data = in_data[k*N +: N];
        sel_err  = 1'b0;
      end
  end
  assign in_ready   = ~skid_valid & ~rst;
  assign acc        = in_valid & in_ready;
  assign emit       = main_valid & out_ready;
  assign out_data   = main_data;
  assign out_valid  = main_valid;
  assign out_selerr = main_err;
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      main_err   <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (emit) begin
        main_data  <= skid_data;
        main_err   <= skid_err;
        skid_valid <= 1'b0;
      end
    end else if (!main_valid || emit) begin
      main_valid <= acc;
      if (acc) begin
        main_data <= sel_data;
        main_err  <= sel_err;
      end
    end else if (acc) begin
      skid_data  <= sel_data;
      skid_err   <= sel_err;
      skid_valid <= 1'b1;
    end
  end
endmodule
